// File: rtl/font_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// font_rom_arbiter_if : requester/ROM bundle for the font ROM arbiter
// Rev 1.0
// ============================================================================
interface font_rom_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_vld;

  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_gnt;
  logic [DATA_W-1:0] bg_data;
  logic              bg_vld;

  logic              starve_clr;
  logic              bg_starve;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // Arbiter side
  modport slave (
    input  disp_req, disp_addr, bg_req, bg_addr, starve_clr, rom_data,
    output disp_data, disp_vld, bg_gnt, bg_data, bg_vld, bg_starve, rom_addr
  );

  // Requesters + ROM side
  modport master (
    output disp_req, disp_addr, bg_req, bg_addr, starve_clr, rom_data,
    input  disp_data, disp_vld, bg_gnt, bg_data, bg_vld, bg_starve, rom_addr
  );
endinterface
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// font_rom_arbiter : shares one font ROM between the display path (priority)
//                    and a background renderer; rows return by issue tag.
// Rev 1.0
// ============================================================================
module font_rom_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_LIM = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  font_rom_arbiter_if.slave bus
);

  localparam int TAG_D = ROM_LAT + 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starve_q, starve_d;
  logic [TAG_D-1:0]  tag_disp_q, tag_disp_d;
  logic [TAG_D-1:0]  tag_bg_q, tag_bg_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DATA_W-1:0] bg_data_q, bg_data_d;
  logic              disp_vld_q, disp_vld_d;
  logic              bg_vld_q, bg_vld_d;
  logic              gnt;
  logic              disp_ret;
  logic              bg_ret;

  // Tags leaving the pipe line up with rom_data for the read they describe
  assign disp_ret = tag_disp_q[TAG_D-1];
  assign bg_ret   = tag_bg_q[TAG_D-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.bg_req) begin
          if (!bus.disp_req) begin
            gnt     = 1'b1;
            state_d = ST_ISSUED;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.bg_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!bus.disp_req) begin
          gnt     = 1'b1;
          state_d = ST_ISSUED;
          cnt_d   = '0;
        end else if (cnt_q != CNT_LIM) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_ISSUED: begin
        if (bg_ret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (bus.starve_clr) begin
      starve_d = 1'b0;
    end else if ((cnt_d == CNT_LIM) && (cnt_q != CNT_LIM)) begin
      starve_d = 1'b1;
    end
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (bus.disp_req) begin
      rom_addr_d = bus.disp_addr;
    end else if (gnt) begin
      rom_addr_d = bus.bg_addr;
    end
    tag_disp_d = {tag_disp_q[TAG_D-2:0], bus.disp_req};
    tag_bg_d   = {tag_bg_q[TAG_D-2:0], gnt & ~bus.disp_req};
  end

  always_comb begin
    disp_vld_d  = disp_ret;
    bg_vld_d    = bg_ret;
    disp_data_d = disp_data_q;
    bg_data_d   = bg_data_q;
    if (disp_ret) begin
      disp_data_d = bus.rom_data;
    end
    if (bg_ret) begin
      bg_data_d = bus.rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
      tag_disp_q  <= '0;
      tag_bg_q    <= '0;
      rom_addr_q  <= '0;
      disp_data_q <= '0;
      bg_data_q   <= '0;
      disp_vld_q  <= 1'b0;
      bg_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      tag_disp_q  <= tag_disp_d;
      tag_bg_q    <= tag_bg_d;
      rom_addr_q  <= rom_addr_d;
      disp_data_q <= disp_data_d;
      bg_data_q   <= bg_data_d;
      disp_vld_q  <= disp_vld_d;
      bg_vld_q    <= bg_vld_d;
    end
  end

  // Grant is combinational from the requests, so hold it low while in reset
  assign bus.bg_gnt    = gnt & rst_n;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.disp_data = disp_data_q;
  assign bus.disp_vld  = disp_vld_q;
  assign bus.bg_data   = bg_data_q;
  assign bus.bg_vld    = bg_vld_q;
  assign bus.bg_starve = starve_q;

endmodule
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tb_font_rom_arbiter : directed table, corner sequences and random traffic
//                       against a slot-queue reference model.
// Rev 1.0
// ============================================================================
module tb_font_rom_arbiter;

  localparam int LIM = 16;

  logic clk;
  logic rst_n;

  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  font_rom_arbiter #(
    .ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .STARVE_LIM(LIM)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[4:0]} ^ 8'h5A;
  endfunction

  // Font ROM with one clock of read latency
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  int checks;
  int failures;

  // Reference model: reads scheduled into result slots by due edge
  int          n;
  int          kind [8];
  logic [10:0] qaddr [8];
  logic        bg_out;
  int          bg_due;
  int          wcnt;
  logic        e_dvld, e_bvld, e_starve;
  logic [7:0]  e_ddata, e_bdata;
  logic [10:0] e_rom;
  logic        last_gnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, n, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      kind[i]  = 0;
      qaddr[i] = '0;
    end
    bg_out   = 1'b0;
    bg_due   = 0;
    wcnt     = 0;
    e_dvld   = 1'b0;
    e_bvld   = 1'b0;
    e_starve = 1'b0;
    e_ddata  = '0;
    e_bdata  = '0;
    e_rom    = '0;
  endtask

  task automatic step(input logic dr, input logic [10:0] da, input logic br,
                      input logic [10:0] ba, input logic clr);
    logic busy, eg, reached;
    int   k, j;
    bus.disp_req   = dr;
    bus.disp_addr  = da;
    bus.bg_req     = br;
    bus.bg_addr    = ba;
    bus.starve_clr = clr;
    @(negedge clk);
    busy     = bg_out && (n <= bg_due);
    eg       = br && !dr && !busy;
    last_gnt = bus.bg_gnt;
    chk("bg_gnt", bus.bg_gnt, eg);
    @(posedge clk);
    k      = n % 8;
    e_dvld = (kind[k] == 1);
    e_bvld = (kind[k] == 2);
    if (e_dvld) e_ddata = rom_fn(qaddr[k]);
    if (e_bvld) e_bdata = rom_fn(qaddr[k]);
    kind[k] = 0;
    if (bg_out && n >= bg_due) bg_out = 1'b0;
    j = (n + 2) % 8;
    if (dr) begin
      kind[j] = 1; qaddr[j] = da; e_rom = da;
    end else if (eg) begin
      kind[j] = 2; qaddr[j] = ba; e_rom = ba;
      bg_out = 1'b1; bg_due = n + 2;
    end
    reached = 1'b0;
    if (br && !eg && !busy) begin
      if (wcnt < LIM) begin
        wcnt++;
        reached = (wcnt == LIM);
      end
    end else begin
      wcnt = 0;
    end
    if (clr) e_starve = 1'b0;
    else if (reached) e_starve = 1'b1;
    #1;
    chk("disp_vld", bus.disp_vld, e_dvld);
    chk("bg_vld", bus.bg_vld, e_bvld);
    chk("disp_data", bus.disp_data, e_ddata);
    chk("bg_data", bus.bg_data, e_bdata);
    chk("bg_starve", bus.bg_starve, e_starve);
    chk("rom_addr", bus.rom_addr, e_rom);
    n++;
  endtask

  typedef struct {
    logic        dr;
    logic [10:0] da;
    logic        br;
    logic [10:0] ba;
    logic        eg;
    logic        edv;
    logic        ebv;
  } vec_t;

  vec_t tbl [28];

  task automatic tv(input int i, input logic dr, input logic [10:0] da, input logic br,
                    input logic [10:0] ba, input logic eg, input logic edv, input logic ebv);
    tbl[i].dr = dr; tbl[i].da = da; tbl[i].br = br; tbl[i].ba = ba;
    tbl[i].eg = eg; tbl[i].edv = edv; tbl[i].ebv = ebv;
  endtask

  logic        bg_pend;
  logic [10:0] bg_a, d_a;
  logic        dr_r, clr_r;
  int          dens;

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    model_reset();

    // display stream, idle-slot background, collision, interleave
    for (int i = 0; i < 8; i++)
      tv(i, 1'b1, 11'h410 + 11'(i), 1'b0, 11'h000, 1'b0, (i >= 2), 1'b0);
    tv(8,  1'b0, 11'h000, 1'b1, 11'h2A3, 1'b1, 1'b1, 1'b0);
    tv(9,  1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0);
    tv(10, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      tv(11 + i, 1'b1, 11'h020 + 11'(i), 1'b1, 11'h155, 1'b0, (i >= 2), 1'b0);
    tv(16, 1'b0, 11'h000, 1'b1, 11'h155, 1'b1, 1'b1, 1'b0);
    tv(17, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0);
    tv(18, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1);
    tv(19, 1'b1, 11'h030, 1'b1, 11'h1B0, 1'b0, 1'b0, 1'b0);
    tv(20, 1'b0, 11'h000, 1'b1, 11'h1B0, 1'b1, 1'b0, 1'b0);
    tv(21, 1'b1, 11'h031, 1'b1, 11'h300, 1'b0, 1'b1, 1'b0);
    tv(22, 1'b0, 11'h000, 1'b1, 11'h300, 1'b0, 1'b0, 1'b1);
    tv(23, 1'b1, 11'h032, 1'b1, 11'h300, 1'b0, 1'b1, 1'b0);
    tv(24, 1'b0, 11'h000, 1'b1, 11'h300, 1'b1, 1'b0, 1'b0);
    tv(25, 1'b1, 11'h033, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0);
    tv(26, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1);
    tv(27, 1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0);

    bus.disp_req = 1'b0; bus.disp_addr = '0; bus.bg_req = 1'b0;
    bus.bg_addr = '0; bus.starve_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_disp_vld", bus.disp_vld, 0);
    chk("rst_bg_vld", bus.bg_vld, 0);
    chk("rst_bg_starve", bus.bg_starve, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].dr, tbl[i].da, tbl[i].br, tbl[i].ba, 1'b0);
      chk("tbl_gnt", last_gnt, tbl[i].eg);
      chk("tbl_disp_vld", bus.disp_vld, tbl[i].edv);
      chk("tbl_bg_vld", bus.bg_vld, tbl[i].ebv);
    end

    // starvation: display held 20 cycles over a pending background request
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 11'h500 + 11'(i), 1'b1, 11'h4C5, 1'b0);
      chk("starve_ramp", bus.bg_starve, (i >= 15));
    end
    step(1'b0, 11'h000, 1'b1, 11'h4C5, 1'b0);
    chk("starve_gnt", last_gnt, 1);
    repeat (3) step(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);
    chk("starve_sticky", bus.bg_starve, 1);
    step(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
    chk("starve_clr", bus.bg_starve, 0);

    // random traffic with shifting display density
    bg_pend = 1'b0;
    bg_a    = '0;
    dens    = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       dens = 30;
          1:       dens = 70;
          default: dens = 100;
        endcase
      end
      if (!bg_pend && ($urandom_range(0, 2) == 0)) begin
        bg_pend = 1'b1;
        bg_a    = 11'($urandom_range(0, 2047));
      end
      d_a   = 11'($urandom_range(0, 2047));
      dr_r  = ($urandom_range(0, 99) < dens);
      clr_r = ($urandom_range(0, 49) == 0);
      step(dr_r, d_a, bg_pend, bg_a, clr_r);
      if (last_gnt) bg_pend = 1'b0;
    end
    repeat (4) step(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);

    // reset one cycle after a background grant
    step(1'b0, 11'h000, 1'b1, 11'h2A3, 1'b0);
    chk("mid_gnt", last_gnt, 1);
    step(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rom_addr", bus.rom_addr, 0);
    chk("mid_rst_disp_data", bus.disp_data, 0);
    chk("mid_rst_bg_data", bus.bg_data, 0);
    chk("mid_rst_bg_vld", bus.bg_vld, 0);
    chk("mid_rst_bg_gnt", bus.bg_gnt, 0);
    chk("mid_rst_starve", bus.bg_starve, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);
      chk("post_rst_no_bg_vld", bus.bg_vld, 0);
    end
    step(1'b0, 11'h000, 1'b1, 11'h0F0, 1'b0);
    chk("post_rst_idle_gnt", last_gnt, 1);
    repeat (3) step(1'b0, 11'h000, 1'b0, 11'h000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
